spi_sysbus_ctrl: RTL and testbench

SPI_SYSBUS_CTRL -- requirements
Module: spi_sysbus_ctrl

---
 rtl/spi_sb_pkg.sv | 45 ++++
 rtl/spi_sb_xact.sv | 90 +++++++++
 rtl/spi_sysbus_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_spi_sysbus_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sb_pkg.sv
// Shared definitions for the SB_SPI system-bus controller.
// Holds the register map, the SPISR bit positions, the arbiter state encoding
// and the helper that maps the init index to its config register address.
package spi_sb_pkg;

  // SB_SPI register map
  localparam logic [7:0] ADR_SPICR0  = 8'h08;
  localparam logic [7:0] ADR_SPICR1  = 8'h09;
  localparam logic [7:0] ADR_SPICR2  = 8'h0A;
  localparam logic [7:0] ADR_SPIBR   = 8'h0B;
  localparam logic [7:0] ADR_SPISR   = 8'h0C;
  localparam logic [7:0] ADR_SPITXDR = 8'h0D;
  localparam logic [7:0] ADR_SPIRXDR = 8'h0E;
  localparam logic [7:0] ADR_SPICSR  = 8'h0F;

  // SPISR bit positions
  localparam int unsigned SR_ROE_BIT  = 1;
  localparam int unsigned SR_RRDY_BIT = 3;
  localparam int unsigned SR_TRDY_BIT = 4;

  // Index of the last config write (CSR)
  localparam logic [2:0] INIT_LAST = 3'd4;

  typedef enum logic [1:0] {
    ST_INIT_WR = 2'd0,
    ST_POLL_SR = 2'd1,
    ST_RD_RXDR = 2'd2,
    ST_WR_TXDR = 2'd3
  } state_e;

  function automatic logic [7:0] init_adr(input logic [2:0] idx);
    logic [7:0] adr;
    adr = ADR_SPICR0;
    case (idx)
      3'd0:    adr = ADR_SPICR0;
      3'd1:    adr = ADR_SPICR1;
      3'd2:    adr = ADR_SPICR2;
      3'd3:    adr = ADR_SPIBR;
      3'd4:    adr = ADR_SPICSR;
      default: adr = ADR_SPICR0;
    endcase
    return adr;
  endfunction

endpackage

// File: rtl/spi_sb_xact.sv
// System-bus transaction engine: raises sb_stb for one transaction, holds the
// address/direction/data stable while it is high, and drops it either the
// cycle after sb_ack or after ACK_TIMEOUT cycles without an ack.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             request a transaction (taken only while idle)
//   rw_i/adr_i/dati_i   transaction fields, captured when the strobe starts
//   sb_ack_i            bus acknowledge
//   sb_stb_o/sb_rw_o/sb_adr_o/sb_dati_o  registered bus outputs
//   done_o              transaction acked this cycle
//   timeout_o           transaction abandoned this cycle (no ack in time)
module spi_sb_xact
  import spi_sb_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [7:0] adr_i,
  input  logic [7:0] dati_i,
  input  logic       sb_ack_i,
  output logic       sb_stb_o,
  output logic       sb_rw_o,
  output logic [7:0] sb_adr_o,
  output logic [7:0] sb_dati_o,
  output logic       done_o,
  output logic       timeout_o
);

  // The count is loaded on the first strobe cycle, so the strobe stays high
  // for exactly ACK_TIMEOUT cycles before the terminal count drops it.
  localparam logic [7:0] CNT_LOAD = 8'(ACK_TIMEOUT - 1);

  logic       stb_q, stb_d;
  logic       rw_q, rw_d;
  logic [7:0] adr_q, adr_d;
  logic [7:0] dati_q, dati_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cnt_tc;

  assign cnt_tc = (cnt_q == 8'd0);

  always_comb begin
    stb_d  = stb_q;
    rw_d   = rw_q;
    adr_d  = adr_q;
    dati_d = dati_q;
    cnt_d  = cnt_q;
    if (stb_q) begin
      if (sb_ack_i || cnt_tc) begin
        stb_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end else if (start_i) begin
      // Idle for at least one cycle here, which gives the mandatory low gap.
      stb_d  = 1'b1;
      rw_d   = rw_i;
      adr_d  = adr_i;
      dati_d = dati_i;
      cnt_d  = CNT_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q  <= 1'b0;
      rw_q   <= 1'b0;
      adr_q  <= 8'h00;
      dati_q <= 8'h00;
      cnt_q  <= 8'h00;
    end else begin
      stb_q  <= stb_d;
      rw_q   <= rw_d;
      adr_q  <= adr_d;
      dati_q <= dati_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sb_stb_o  = stb_q;
  assign sb_rw_o   = rw_q;
  assign sb_adr_o  = adr_q;
  assign sb_dati_o = dati_q;
  assign done_o    = stb_q & sb_ack_i;
  assign timeout_o = stb_q & ~sb_ack_i & cnt_tc;

endmodule

// File: rtl/spi_sysbus_ctrl.sv
// SB_SPI system-bus controller: writes the five config registers after reset,
// then polls SPISR and moves bytes between the SPI core and a valid/ready
// RX stream and a valid/ready TX stream, round-robin when both are ready.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   sb_stb/sb_rw/sb_adr/sb_dati    system-bus request to SB_SPI
//   sb_dato/sb_ack                 system-bus response from SB_SPI
//   rx_data/rx_valid/rx_ready      received byte stream
//   tx_data/tx_valid/tx_ready      transmit byte stream (tx_ready = consumed)
//   init_done                      config sequence complete
//   err_timeout/err_overrun        sticky error flags
//
// state      | meaning
// ST_INIT_WR | writing config register idx_q (CR0, CR1, CR2, BR, CSR)
// ST_POLL_SR | reading SPISR and choosing the next data transfer
// ST_RD_RXDR | reading SPIRXDR into rx_data
// ST_WR_TXDR | writing tx_data to SPITXDR
module spi_sysbus_ctrl
  import spi_sb_pkg::*;
#(
  parameter logic [7:0]  CR0_VAL     = 8'h00,
  parameter logic [7:0]  CR1_VAL     = 8'h80,
  parameter logic [7:0]  CR2_VAL     = 8'h01,
  parameter logic [7:0]  BR_VAL      = 8'h00,
  parameter logic [7:0]  CSR_VAL     = 8'h00,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  output logic       sb_stb,
  output logic       sb_rw,
  output logic [7:0] sb_adr,
  output logic [7:0] sb_dati,
  input  logic [7:0] sb_dato,
  input  logic       sb_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       init_done,
  output logic       err_timeout,
  output logic       err_overrun
);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       init_done_q, init_done_d;
  logic       err_to_q, err_to_d;
  logic       err_ov_q, err_ov_d;
  logic       rr_rx_q, rr_rx_d;     // 1: RX wins the next tie

  logic       x_rw;
  logic [7:0] x_adr;
  logic [7:0] x_dati;
  logic       x_done;
  logic       x_timeout;
  logic [7:0] init_val;
  logic       rx_elig;
  logic       tx_elig;

  always_comb begin
    init_val = CR0_VAL;
    case (idx_q)
      3'd0:    init_val = CR0_VAL;
      3'd1:    init_val = CR1_VAL;
      3'd2:    init_val = CR2_VAL;
      3'd3:    init_val = BR_VAL;
      3'd4:    init_val = CSR_VAL;
      default: init_val = CR0_VAL;
    endcase
  end

  // Request fields for the current state; the engine captures them only when
  // the strobe starts, so a retry after timeout re-issues the same request.
  always_comb begin
    x_rw   = 1'b0;
    x_adr  = ADR_SPISR;
    x_dati = 8'h00;
    case (state_q)
      ST_INIT_WR: begin
        x_rw   = 1'b1;
        x_adr  = init_adr(idx_q);
        x_dati = init_val;
      end
      ST_POLL_SR: x_adr = ADR_SPISR;
      ST_RD_RXDR: x_adr = ADR_SPIRXDR;
      ST_WR_TXDR: begin
        x_rw   = 1'b1;
        x_adr  = ADR_SPITXDR;
        x_dati = tx_data;
      end
      default: x_adr = ADR_SPISR;
    endcase
  end

  spi_sb_xact #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_xact (
    .clk       (clk),
    .rst       (rst),
    .start_i   (~rst),
    .rw_i      (x_rw),
    .adr_i     (x_adr),
    .dati_i    (x_dati),
    .sb_ack_i  (sb_ack),
    .sb_stb_o  (sb_stb),
    .sb_rw_o   (sb_rw),
    .sb_adr_o  (sb_adr),
    .sb_dati_o (sb_dati),
    .done_o    (x_done),
    .timeout_o (x_timeout)
  );

  assign rx_elig = sb_dato[SR_RRDY_BIT] & ~rx_valid_q;
  assign tx_elig = sb_dato[SR_TRDY_BIT] & tx_valid;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    init_done_d = init_done_q;
    err_to_d    = err_to_q;
    err_ov_d    = err_ov_q;
    rr_rx_d     = rr_rx_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (x_timeout) begin
      err_to_d = 1'b1;
    end

    case (state_q)
      ST_INIT_WR: begin
        if (x_done) begin
          if (idx_q == INIT_LAST) begin
            init_done_d = 1'b1;
            idx_d       = 3'd0;
            state_d     = ST_POLL_SR;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_POLL_SR: begin
        if (x_done) begin
          if (sb_dato[SR_ROE_BIT]) begin
            err_ov_d = 1'b1;
          end
          if (rx_elig && (!tx_elig || rr_rx_q)) begin
            state_d = ST_RD_RXDR;
            rr_rx_d = 1'b0;
          end else if (tx_elig) begin
            state_d = ST_WR_TXDR;
            rr_rx_d = 1'b1;
          end
        end
      end
      ST_RD_RXDR: begin
        if (x_done) begin
          rx_data_d  = sb_dato;
          rx_valid_d = 1'b1;
          state_d    = ST_POLL_SR;
        end
      end
      ST_WR_TXDR: begin
        if (x_done) begin
          state_d = ST_POLL_SR;
        end
      end
      default: state_d = ST_INIT_WR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT_WR;
      idx_q       <= 3'd0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      err_to_q    <= 1'b0;
      err_ov_q    <= 1'b0;
      rr_rx_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      init_done_q <= init_done_d;
      err_to_q    <= err_to_d;
      err_ov_q    <= err_ov_d;
      rr_rx_q     <= rr_rx_d;
    end
  end

  // Combinational so the pulse lands on the ack cycle itself; gated by rst
  // because the strobe is only cleared at the reset edge.
  assign tx_ready    = ~rst & x_done & (state_q == ST_WR_TXDR);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign init_done   = init_done_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_spi_sysbus_ctrl.sv
// Directed testbench for spi_sysbus_ctrl with a small SB_SPI bus model that
// acks two cycles after the strobe rises and can withhold the SPICR1 ack.
module tb_spi_sysbus_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sb_stb;
  logic       sb_rw;
  logic [7:0] sb_adr;
  logic [7:0] sb_dati;
  logic [7:0] sb_dato;
  logic       sb_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       init_done;
  logic       err_timeout;
  logic       err_overrun;

  logic [7:0] spisr_val = 8'h00;
  logic [7:0] rxdr_val  = 8'h00;
  logic       hold_09   = 1'b0;
  logic [1:0] mcnt      = 2'd0;

  logic [16:0] xlog [$];   // {rw, adr, dati} of every acked transaction
  int          txr_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  spi_sysbus_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .sb_stb      (sb_stb),
    .sb_rw       (sb_rw),
    .sb_adr      (sb_adr),
    .sb_dati     (sb_dati),
    .sb_dato     (sb_dato),
    .sb_ack      (sb_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .init_done   (init_done),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  assign sb_dato = (sb_adr == 8'h0C) ? spisr_val :
                   (sb_adr == 8'h0E) ? rxdr_val  : 8'h00;

  always @(posedge clk) begin
    if (!sb_stb || sb_ack) begin
      sb_ack <= 1'b0;
      mcnt   <= 2'd0;
    end else if (hold_09 && sb_adr == 8'h09) begin
      sb_ack <= 1'b0;
    end else if (mcnt == 2'd1) begin
      sb_ack <= 1'b1;
    end else begin
      mcnt <= mcnt + 2'd1;
    end
  end

  always @(posedge clk) begin
    if (sb_stb && sb_ack) xlog.push_back({sb_rw, sb_adr, sb_dati});
    if (tx_ready) txr_cnt <= txr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [16:0] exp_init [5] = '{17'h1_08_00, 17'h1_09_80, 17'h1_0A_01,
                                17'h1_0B_00, 17'h1_0F_00};

  initial begin
    int base, n, rd, sr, t0, nwr, prev_adr, first_adr;
    logic [16:0] e;

    // Reset state
    cyc(3);
    chk("rst_stb", sb_stb, 0);
    chk("rst_rw", sb_rw, 0);
    chk("rst_adr", sb_adr, 0);
    chk("rst_dati", sb_dati, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_err_to", err_timeout, 0);
    chk("rst_err_ov", err_overrun, 0);

    // Init sequence
    base = xlog.size();
    rst = 1'b0;
    for (int i = 0; i < 200 && !init_done; i++) cyc(1);
    chk("init_done", init_done, 1);
    chk("init_count", xlog.size() - base, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("init_wr%0d", i), xlog[base + i], exp_init[i]);
    for (int i = 0; i < 50 && xlog.size() < base + 6; i++) cyc(1);
    chk("first_poll", xlog[base + 5], 17'h0_0C_00);

    // Single RX byte, consumed immediately
    rxdr_val = 8'hA5; rx_ready = 1'b1; spisr_val = 8'h08;
    for (int i = 0; i < 60 && !rx_valid; i++) cyc(1);
    chk("rx_valid_up", rx_valid, 1);
    chk("rx_data_a5", rx_data, 8'hA5);
    cyc(1);
    chk("rx_valid_one_cycle", rx_valid, 0);
    spisr_val = 8'h00;
    cyc(20);

    // Backpressure: one RXDR read only while rx_valid is held
    base = xlog.size();
    rxdr_val = 8'h5A; rx_ready = 1'b0; spisr_val = 8'h08;
    cyc(60);
    rd = 0; sr = 0;
    for (int i = base; i < xlog.size(); i++) begin
      if (xlog[i][15:8] == 8'h0E) rd++;
      if (xlog[i][15:8] == 8'h0C) sr++;
    end
    chk("bp_rd_count", rd, 1);
    chk("bp_polls_continue", (sr >= 3), 1);
    chk("bp_rx_valid_held", rx_valid, 1);
    chk("bp_rx_data", rx_data, 8'h5A);
    spisr_val = 8'h00;
    cyc(5);
    rx_ready = 1'b1;
    cyc(2);
    chk("bp_drained", rx_valid, 0);
    cyc(10);

    // Both sides ready: RX and TX alternate; last grant was RX so TX goes first
    base = xlog.size(); t0 = txr_cnt;
    rxdr_val = 8'h77; tx_data = 8'h3C; tx_valid = 1'b1; spisr_val = 8'h18;
    cyc(120);
    spisr_val = 8'h00; tx_valid = 1'b0;
    cyc(20);
    n = 0; nwr = 0; prev_adr = 0; first_adr = 0;
    for (int i = base; i < xlog.size(); i++) begin
      e = xlog[i];
      if (e[15:8] == 8'h0D || e[15:8] == 8'h0E) begin
        if (n == 0) first_adr = int'(e[15:8]);
        else chk($sformatf("alt_%0d", n), e[15:8], (prev_adr == 8'h0D) ? 8'h0E : 8'h0D);
        if (e[15:8] == 8'h0D) begin
          nwr++;
          chk($sformatf("alt_wdata_%0d", n), e[7:0], 8'h3C);
        end
        prev_adr = int'(e[15:8]);
        n++;
      end
    end
    chk("alt_enough", (n >= 4), 1);
    chk("alt_first_tx", first_adr, 8'h0D);
    chk("tx_ready_pulses", txr_cnt - t0, nwr);

    // tx_valid dropped mid-write: the write still completes with sampled data
    t0 = txr_cnt;
    tx_data = 8'h99; tx_valid = 1'b1; spisr_val = 8'h10;
    for (int i = 0; i < 40 && !(sb_stb && sb_adr == 8'h0D); i++) cyc(1);
    chk("txabort_stb", sb_stb && sb_adr == 8'h0D, 1);
    tx_valid = 1'b0; tx_data = 8'h00; spisr_val = 8'h00;
    cyc(10);
    e = 17'h0;
    for (int i = 0; i < xlog.size(); i++) if (xlog[i][15:8] == 8'h0D) e = xlog[i];
    chk("txabort_write", e, 17'h1_0D_99);
    chk("txabort_ready", txr_cnt - t0, 1);

    // Ack withheld on SPICR1: timeout, sticky error, same write retried
    hold_09 = 1'b1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    base = xlog.size();
    for (int i = 0; i < 40 && !(sb_stb && sb_adr == 8'h09); i++) cyc(1);
    chk("to_stb_cr1", sb_stb && sb_adr == 8'h09, 1);
    n = 0;
    while (sb_stb && n < 400) begin
      n++;
      cyc(1);
    end
    chk("to_cycles", n, 255);
    chk("to_err", err_timeout, 1);
    chk("to_no_init", init_done, 0);
    hold_09 = 1'b0;
    for (int i = 0; i < 5 && !sb_stb; i++) cyc(1);
    chk("to_retry_adr", {sb_stb, sb_rw, sb_adr, sb_dati}, {2'b11, 8'h09, 8'h80});
    for (int i = 0; i < 100 && !init_done; i++) cyc(1);
    chk("to_init_done", init_done, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("to_init_wr%0d", i), xlog[base + i], exp_init[i]);
    chk("to_sticky", err_timeout, 1);

    // Overrun flag
    chk("ov_clear", err_overrun, 0);
    spisr_val = 8'h02;
    cyc(20);
    chk("ov_set", err_overrun, 1);
    spisr_val = 8'h00;
    cyc(10);
    chk("ov_sticky", err_overrun, 1);

    // Reset while the TXDR strobe is high
    tx_data = 8'hC3; tx_valid = 1'b1; spisr_val = 8'h10;
    for (int i = 0; i < 40 && !(sb_stb && sb_adr == 8'h0D); i++) cyc(1);
    chk("rst_mid_stb", sb_stb && sb_adr == 8'h0D, 1);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_stb_low", sb_stb, 0);
    chk("rst_mid_tx_ready", tx_ready, 0);
    chk("rst_mid_err_to", err_timeout, 0);
    chk("rst_mid_err_ov", err_overrun, 0);
    chk("rst_mid_init_done", init_done, 0);
    rst = 1'b0;
    base = xlog.size();
    rx_ready = 1'b1; spisr_val = 8'h18;
    for (int i = 0; i < 100 && !init_done; i++) cyc(1);
    chk("restart_init_done", init_done, 1);
    chk("restart_cr0", xlog[base], 17'h1_08_00);
    first_adr = 0;
    for (int i = 0; i < 60 && first_adr == 0; i++) begin
      cyc(1);
      for (int j = base + 5; j < xlog.size(); j++)
        if (first_adr == 0 && (xlog[j][15:8] == 8'h0D || xlog[j][15:8] == 8'h0E))
          first_adr = int'(xlog[j][15:8]);
    end
    chk("rr_reset_rx_first", first_adr, 8'h0E);
    spisr_val = 8'h00; tx_valid = 1'b0;
    cyc(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
